// File: rtl/secded_pkg.sv
// Shared SECDED(39,32) definitions: widths, parity positions and the
// data-to-codeword bit map used by both the encoder and the scrub decoder.
//   CW_W     codeword width (32 data + 6 Hamming parity + 1 overall parity)
//   PAR_IDX  Hamming parity positions (2^k - 1)
//   OVP_IDX  overall-parity position
//   DATA_IDX codeword index of data bit i
package secded_pkg;
  localparam int CW_W   = 39;
  localparam int DATA_W = 32;
  localparam int SYN_W  = 6;

  localparam int PAR_IDX [SYN_W] = '{0, 1, 3, 7, 15, 31};
  localparam int OVP_IDX = 38;

  localparam int DATA_IDX [DATA_W] = '{
     2,  4,  5,  6,  8,  9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20,
    21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 32, 33, 34, 35, 36, 37
  };

  typedef struct packed {
    logic [CW_W-1:0]  cw;
    logic [SYN_W-1:0] syn;
    logic             par;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CW_W-1:0]   cw;
    logic              ce;
    logic              ue;
    logic [SYN_W-1:0]  syn;
  } s2_t;

  // Gather the data bits out of a codeword.
  function automatic logic [DATA_W-1:0] cw_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W; i++) d[i] = cw[DATA_IDX[i]];
    return d;
  endfunction
endpackage

// File: rtl/secded_syndrome.sv
// Combinational SECDED checker.
//   cw  : 39-bit codeword
//   syn : Hamming syndrome; bit k = XOR of cw[j-1] over positions j (1..38)
//         with bit k of j set. The overall-parity bit is not part of it.
//   par : XOR of all codeword bits (1 = odd number of flipped bits)
module secded_syndrome
  import secded_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [SYN_W-1:0] syn,
  output logic             par
);
  always_comb begin
    syn = '0;
    for (int j = 1; j < CW_W; j++)
      for (int k = 0; k < SYN_W; k++)
        if (j[k]) syn[k] = syn[k] ^ cw[j-1];
  end

  assign par = ^cw;
endmodule

// File: rtl/secded_scrub_decoder.sv
// Two-stage SECDED(39,32) scrub decoder with ready/valid on both sides.
//   in_valid/in_ready/in_cw    : codeword input
//   out_valid/out_ready        : result handshake
//   out_data, out_cw           : corrected data / codeword (raw on out_ue)
//   out_ce, out_ue, out_syn    : corrected / uncorrectable flags, syndrome
//   ce_count, ue_count         : saturating counters, bumped on handshake
//   cnt_clr                    : clears both counters, beats an increment
// Stage 1 registers codeword+syndrome+parity, stage 2 the corrected result.
module secded_scrub_decoder
  import secded_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW_W-1:0]   out_cw,
  output logic              out_ce,
  output logic              out_ue,
  output logic [SYN_W-1:0]  out_syn,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  input  logic              cnt_clr
);
  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1_q;
  s2_t              s2_q, s2_d;
  logic [SYN_W-1:0] syn;
  logic             par;
  logic [SYN_W-1:0] fidx;
  logic             s1_adv, s2_adv, hs;

  secded_syndrome u_syn (.cw(in_cw), .syn(syn), .par(par));

  assign s2_adv   = !vld_pipe[2] | out_ready;
  assign s1_adv   = !vld_pipe[1] | s2_adv;
  assign in_ready = s1_adv;
  assign hs       = vld_pipe[2] & out_ready;

  // Zero syndrome with odd parity means only the overall-parity bit flipped.
  assign fidx = (s1_q.syn == '0) ? SYN_W'(OVP_IDX) : s1_q.syn - SYN_W'(1);

  always_comb begin
    s2_d     = '0;
    s2_d.cw  = s1_q.cw;
    s2_d.syn = s1_q.syn;
    if (s1_q.syn == '0 && !s1_q.par) begin
      // clean
    end else if (s1_q.par && s1_q.syn <= SYN_W'(OVP_IDX)) begin
      s2_d.cw = s1_q.cw ^ (CW_W'(1) << fidx);
      s2_d.ce = 1'b1;
    end else begin
      // even parity with nonzero syndrome, or a syndrome past the codeword
      s2_d.ue = 1'b1;
    end
    s2_d.data = cw_data(s2_d.cw);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= '{cw: in_cw, syn: syn, par: par};
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (hs) begin
      if (s2_q.ce && ce_count != CNT_MAX) ce_count <= ce_count + 1'b1;
      if (s2_q.ue && ue_count != CNT_MAX) ue_count <= ue_count + 1'b1;
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_data  = s2_q.data;
  assign out_cw    = s2_q.cw;
  assign out_ce    = s2_q.ce;
  assign out_ue    = s2_q.ue;
  assign out_syn   = s2_q.syn;
endmodule

// File: tb/tb_secded_scrub_decoder.sv
module tb_secded_scrub_decoder;
  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [38:0] in_cw = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [38:0] out_cw;
  logic        out_ce, out_ue;
  logic [5:0]  out_syn;
  logic [CNT_W-1:0] ce_count, ue_count;
  logic        cnt_clr = 1'b0;

  secded_scrub_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cw(out_cw), .out_ce(out_ce), .out_ue(out_ue),
    .out_syn(out_syn), .ce_count(ce_count), .ue_count(ue_count),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [38:0] cw;
    logic        ce;
    logic        ue;
    logic [5:0]  syn;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int acc = 0;
  bit bp_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [38:0] cw, input logic [31:0] d, input logic [38:0] ocw,
                      input logic ce, input logic ue, input logic [5:0] syn);
    exp_t e;
    bit ok = 0;
    in_valid = 1'b1;
    in_cw = cw;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stuck 0 for cw 0x%0h", cw);
    end else begin
      e.d = d; e.cw = ocw; e.ce = ce; e.ue = ue; e.syn = syn;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ok) acc++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    cyc(1);
  endtask

  // Monitor: compare every delivered result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: data 0x%0h with empty scoreboard", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_cw",   64'(out_cw),   64'(e.cw));
        chk("out_ce",   64'(out_ce),   64'(e.ce));
        chk("out_ue",   64'(out_ue),   64'(e.ue));
        chk("out_syn",  64'(out_syn),  64'(e.syn));
      end
      chk("ce_ue_excl", 64'(out_ce & out_ue), 64'd0);
    end
  end

  logic [38:0] rec_cw;

  initial begin
    cyc(3);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_cw",    64'(out_cw),    64'd0);
    chk("rst_flags",     64'({out_ce, out_ue, out_syn}), 64'd0);
    chk("rst_ce_count",  64'(ce_count),  64'd0);
    chk("rst_ue_count",  64'(ue_count),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Clean word with latency check.
    out_ready = 1'b1;
    send(39'h4000000007, 32'h1, 39'h4000000007, 0, 0, 6'd0);
    @(negedge clk);
    chk("lat_cycle1_invalid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Back-to-back: single data error, overall-parity only, double, out-of-range.
    send(39'h4000000003, 32'h1, 39'h4000000007, 1, 0, 6'd3);
    send(39'h4000000000, 32'h0, 39'h0,          1, 0, 6'd0);
    send(39'h14,         32'h3, 39'h14,         0, 1, 6'd6);
    send(39'h80000081,   32'h0, 39'h80000081,   0, 1, 6'd41);
    drain();
    chk("ce_count_2", 64'(ce_count), 64'd2);
    chk("ue_count_2", 64'(ue_count), 64'd2);

    // Reset while a word is in stage 1: it must vanish.
    send(39'h1, 32'h0, 39'h0, 1, 0, 6'd1);
    rst_n = 1'b0;
    cyc(2);
    sb.delete();
    rst_n = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_ce_count",  64'(ce_count),  64'd0);
    chk("midrst_ue_count",  64'(ue_count),  64'd0);
    @(posedge clk); #1;

    // Back-pressure: four CE words, only two fit.
    out_ready = 1'b0;
    acc = 0;
    fork
      begin
        send(39'h4000000003, 32'h1, 39'h4000000007, 1, 0, 6'd3);
        send(39'h1,          32'h0, 39'h0,          1, 0, 6'd1);
        send(39'h2000000000, 32'h0, 39'h0,          1, 0, 6'd38);
        send(39'h4000000000, 32'h0, 39'h0,          1, 0, 6'd0);
        bp_done = 1;
      end
    join_none
    repeat (6) @(negedge clk);
    chk("bp_accepted",  64'(acc),       64'd2);
    chk("bp_in_ready",  64'(in_ready),  64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_out_syn",   64'(out_syn),   64'd3);
    rec_cw = out_cw;
    repeat (3) @(negedge clk);
    chk("bp_stable_cw",   64'(out_cw),   64'(rec_cw));
    chk("bp_stable_data", 64'(out_data), 64'h1);
    chk("bp_stable_ce",   64'(out_ce),   64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !bp_done; i++) @(posedge clk);
    chk("bp_sender_done", 64'(bp_done), 64'd1);
    drain();
    chk("bp_all_accepted", 64'(acc), 64'd4);
    chk("ce_sat_4", 64'(ce_count), 64'd3);
    send(39'h4, 32'h0, 39'h0, 1, 0, 6'd3);
    drain();
    chk("ce_sat_5", 64'(ce_count), 64'd3);
    chk("ue_after_ce", 64'(ue_count), 64'd0);

    // cnt_clr coincident with a CE handshake: clear wins.
    out_ready = 1'b0;
    send(39'h1, 32'h0, 39'h0, 1, 0, 6'd1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("clr_word_ready", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins_ce", 64'(ce_count), 64'd0);
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
